dma_arbiter: RTL and testbench

DMA_ARBITER -- requirements
Module: dma_arbiter

---
 rtl/dma_arbiter.sv | 144 ++++++++++++++
 tb/tb_dma_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dma_arbiter.sv
// Two-channel round-robin arbiter that owns a single DMA controller,
// with a RUN watchdog and sticky per-channel done/error status.
module dma_arbiter #(
  parameter logic [31:0] TIMEOUT = 32'd65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [31:0] src0,
  input  logic [31:0] dst0,
  input  logic [31:0] len0,
  input  logic [31:0] src1,
  input  logic [31:0] dst1,
  input  logic [31:0] len1,
  input  logic        dma_intr,
  input  logic [1:0]  clr,
  output logic        DMAEN,
  output logic [31:0] DMASRC,
  output logic [31:0] DMADST,
  output logic [31:0] DMALEN,
  output logic [1:0]  grant,
  output logic [1:0]  ack,
  output logic [1:0]  done_sts,
  output logic [1:0]  err_sts,
  output logic        irq,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic        last_grant;

  logic [1:0]  elig;
  logic        pick_vld;
  logic        pick;
  logic [31:0] pick_src;
  logic [31:0] pick_dst;
  logic [31:0] pick_len;
  logic        tmo_hit;
  logic [1:0]  done_set;
  logic [1:0]  err_set;

  // The channel being acked this cycle is masked so it cannot re-win.
  always_comb begin
    elig     = req & ~ack;
    pick_vld = |elig;
    pick     = 1'b0;
    if (&elig)
      pick = ~last_grant;
    else
      pick = elig[1];
  end

  always_comb begin
    pick_src = pick ? src1 : src0;
    pick_dst = pick ? dst1 : dst0;
    pick_len = pick ? len1 : len0;
  end

  // A completion arriving on the timeout cycle counts as success.
  always_comb begin
    tmo_hit  = (cnt == TIMEOUT - 32'd1);
    done_set = 2'b00;
    err_set  = 2'b00;
    if (state == RELEASE && !dma_intr)
      done_set = grant;
    if (state == RUN && !dma_intr && tmo_hit)
      err_set = grant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      DMAEN      <= 1'b0;
      DMASRC     <= 32'd0;
      DMADST     <= 32'd0;
      DMALEN     <= 32'd0;
      grant      <= 2'b00;
      ack        <= 2'b00;
      cnt        <= 32'd0;
      last_grant <= 1'b1;
    end else begin
      ack <= 2'b00;
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            DMASRC     <= pick_src;
            DMADST     <= pick_dst;
            DMALEN     <= pick_len;
            grant      <= pick ? 2'b10 : 2'b01;
            last_grant <= pick;
            cnt        <= 32'd0;
            if (pick_len != 32'd0) begin
              state <= RUN;
              DMAEN <= 1'b1;
            end else begin
              state <= RELEASE;
            end
          end
        end
        RUN: begin
          cnt <= cnt + 32'd1;
          if (dma_intr || tmo_hit) begin
            state <= RELEASE;
            DMAEN <= 1'b0;
          end
        end
        RELEASE: begin
          if (!dma_intr) begin
            state <= IDLE;
            ack   <= grant;
            grant <= 2'b00;
          end
        end
        default: begin
          state <= IDLE;
          DMAEN <= 1'b0;
          grant <= 2'b00;
        end
      endcase
    end
  end

  // Status set beats a clear arriving on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_sts <= 2'b00;
      err_sts  <= 2'b00;
    end else begin
      done_sts <= (done_sts & ~clr) | done_set;
      err_sts  <= (err_sts & ~clr) | err_set;
    end
  end

  assign irq  = |done_sts;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed bench for dma_arbiter: cycle table for round-robin traffic
// plus sequences for timeout, zero length, status clear and reset.
module tb_dma_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [31:0] src0, dst0, len0, src1, dst1, len1;
  logic        dma_intr;
  logic [1:0]  clr;

  logic        en, irq, busy;
  logic [31:0] dsrc, ddst, dlen;
  logic [1:0]  grant, ack, done, err;

  logic        t_en, t_irq, t_busy;
  logic [31:0] t_src, t_dst, t_len;
  logic [1:0]  t_grant, t_ack, t_done, t_err;

  int tests = 0;
  int fails = 0;

  dma_arbiter dut (
    .clk(clk), .rst(rst), .req(req),
    .src0(src0), .dst0(dst0), .len0(len0),
    .src1(src1), .dst1(dst1), .len1(len1),
    .dma_intr(dma_intr), .clr(clr),
    .DMAEN(en), .DMASRC(dsrc), .DMADST(ddst), .DMALEN(dlen),
    .grant(grant), .ack(ack), .done_sts(done), .err_sts(err),
    .irq(irq), .busy(busy)
  );

  dma_arbiter #(.TIMEOUT(32'd8)) dut_t (
    .clk(clk), .rst(rst), .req(req),
    .src0(src0), .dst0(dst0), .len0(len0),
    .src1(src1), .dst1(dst1), .len1(len1),
    .dma_intr(dma_intr), .clr(clr),
    .DMAEN(t_en), .DMASRC(t_src), .DMADST(t_dst), .DMALEN(t_len),
    .grant(t_grant), .ack(t_ack), .done_sts(t_done), .err_sts(t_err),
    .irq(t_irq), .busy(t_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic        intr;
    logic [1:0]  clr;
    logic [1:0]  g;
    logic        en;
    logic [1:0]  ack;
    logic [1:0]  done;
    logic [1:0]  err;
    logic        bsy;
    logic [31:0] src;
  } vec_t;

  vec_t vec [15];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req      = 2'b00;
    dma_intr = 1'b0;
    clr      = 2'b00;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    src0 = 32'h1000; dst0 = 32'h2000; len0 = 32'd16;
    src1 = 32'h3000; dst1 = 32'h4000; len1 = 32'd5;

    // req intr clr | grant en ack done err busy src
    vec[0]  = '{2'b11, 1'b0, 2'b00, 2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 32'h1000};
    vec[1]  = '{2'b11, 1'b0, 2'b00, 2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 32'h1000};
    vec[2]  = '{2'b11, 1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 32'h1000};
    vec[3]  = '{2'b11, 1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 32'h1000};
    vec[4]  = '{2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 32'h1000};
    vec[5]  = '{2'b11, 1'b0, 2'b00, 2'b10, 1'b1, 2'b00, 2'b01, 2'b00, 1'b1, 32'h3000};
    vec[6]  = '{2'b11, 1'b1, 2'b00, 2'b10, 1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 32'h3000};
    vec[7]  = '{2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, 2'b11, 2'b00, 1'b0, 32'h3000};
    vec[8]  = '{2'b11, 1'b0, 2'b00, 2'b01, 1'b1, 2'b00, 2'b11, 2'b00, 1'b1, 32'h1000};
    vec[9]  = '{2'b11, 1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 2'b11, 2'b00, 1'b1, 32'h1000};
    vec[10] = '{2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 2'b11, 2'b00, 1'b0, 32'h1000};
    vec[11] = '{2'b10, 1'b0, 2'b01, 2'b10, 1'b1, 2'b00, 2'b10, 2'b00, 1'b1, 32'h3000};
    vec[12] = '{2'b00, 1'b1, 2'b00, 2'b10, 1'b0, 2'b00, 2'b10, 2'b00, 1'b1, 32'h3000};
    vec[13] = '{2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 32'h3000};
    vec[14] = '{2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 32'h3000};

    // Reset state
    do_reset();
    chk("rst_en", {31'd0, en}, 32'd0);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_ack", {30'd0, ack}, 32'd0);
    chk("rst_done", {30'd0, done}, 32'd0);
    chk("rst_err", {30'd0, err}, 32'd0);
    chk("rst_src", dsrc, 32'd0);
    chk("rst_len", dlen, 32'd0);
    chk("rst_irq_busy", {30'd0, irq, busy}, 32'd0);

    // Round-robin cycle table
    for (int i = 0; i < 15; i++) begin
      req      = vec[i].req;
      dma_intr = vec[i].intr;
      clr      = vec[i].clr;
      tick();
      chk($sformatf("v%0d_grant", i), {30'd0, grant}, {30'd0, vec[i].g});
      chk($sformatf("v%0d_en", i), {31'd0, en}, {31'd0, vec[i].en});
      chk($sformatf("v%0d_ack", i), {30'd0, ack}, {30'd0, vec[i].ack});
      chk($sformatf("v%0d_done", i), {30'd0, done}, {30'd0, vec[i].done});
      chk($sformatf("v%0d_err", i), {30'd0, err}, {30'd0, vec[i].err});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vec[i].bsy});
      chk($sformatf("v%0d_irq", i), {31'd0, irq}, {31'd0, |vec[i].done});
      chk($sformatf("v%0d_src", i), dsrc, vec[i].src);
    end
    clr = 2'b00;

    // Single transfer, completion 20 cycles later, clear collides with set
    do_reset();
    req = 2'b01;
    tick();
    chk("a_grant", {30'd0, grant}, 32'd1);
    chk("a_en", {31'd0, en}, 32'd1);
    chk("a_dst", ddst, 32'h2000);
    chk("a_len", dlen, 32'd16);
    repeat (19) tick();
    chk("a_en_hold", {31'd0, en}, 32'd1);
    dma_intr = 1'b1;
    tick();
    chk("a_en_fall", {31'd0, en}, 32'd0);
    chk("a_ack_wait", {30'd0, ack}, 32'd0);
    dma_intr = 1'b0;
    clr = 2'b01;
    tick();
    chk("a_ack", {30'd0, ack}, 32'd1);
    chk("a_done_setwins", {30'd0, done}, 32'd1);
    chk("a_irq", {31'd0, irq}, 32'd1);
    req = 2'b00;
    tick();
    chk("a_ack_pulse", {30'd0, ack}, 32'd0);
    chk("a_done_clr", {30'd0, done}, 32'd0);
    chk("a_irq_clr", {31'd0, irq}, 32'd0);
    chk("a_grant_idle", {30'd0, grant}, 32'd0);
    clr = 2'b00;

    // Zero-length request on channel 1
    do_reset();
    len1 = 32'd0;
    req = 2'b10;
    tick();
    chk("z_grant", {30'd0, grant}, 32'd2);
    chk("z_en0", {31'd0, en}, 32'd0);
    tick();
    chk("z_ack", {30'd0, ack}, 32'd2);
    chk("z_en1", {31'd0, en}, 32'd0);
    chk("z_done", {30'd0, done}, 32'd2);
    chk("z_err", {30'd0, err}, 32'd0);
    req = 2'b00;
    len1 = 32'd5;

    // Watchdog with TIMEOUT=8
    do_reset();
    req = 2'b01;
    tick();
    chk("t_grant", {30'd0, t_grant}, 32'd1);
    chk("t_en", {31'd0, t_en}, 32'd1);
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (!t_en) break;
    end
    chk("t_run_cycles", n, 32'd8);
    chk("t_err", {30'd0, t_err}, 32'd1);
    tick();
    chk("t_ack", {30'd0, t_ack}, 32'd1);
    chk("t_done", {30'd0, t_done}, 32'd1);
    req = 2'b00;

    // Completion on the timeout cycle is a success
    do_reset();
    req = 2'b01;
    tick();
    repeat (7) tick();
    chk("tc_en_hold", {31'd0, t_en}, 32'd1);
    dma_intr = 1'b1;
    tick();
    chk("tc_en_fall", {31'd0, t_en}, 32'd0);
    chk("tc_err", {30'd0, t_err}, 32'd0);
    dma_intr = 1'b0;
    tick();
    chk("tc_ack", {30'd0, t_ack}, 32'd1);
    chk("tc_done", {30'd0, t_done}, 32'd1);
    chk("tc_err2", {30'd0, t_err}, 32'd0);
    req = 2'b00;

    // Asynchronous reset during RUN
    do_reset();
    req = 2'b11;
    tick();
    chk("r_grant", {30'd0, grant}, 32'd1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("r_en_async", {31'd0, en}, 32'd0);
    chk("r_grant_async", {30'd0, grant}, 32'd0);
    chk("r_ack_async", {30'd0, ack}, 32'd0);
    chk("r_sts_async", {28'd0, done, err}, 32'd0);
    chk("r_busy_async", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("r_regrant", {30'd0, grant}, 32'd1);
    chk("r_regrant_src", dsrc, 32'h1000);
    req = 2'b00;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
